// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared frame layout, chip-select levels, master FSM state
// encoding and small elaboration-time helpers for the SPI master.
package spi_master_pkg;

    localparam int MASTER_FRAME_WIDTH = 24;
    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;

    // Master FSM states, 3-bit encoding kept stable for legacy tooling
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PRE   = 3'd2;
    localparam logic [2:0] ST_XFER  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Largest of three timing parameters; sizes the shared phase timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides sysclk by 2*CLK_DIV to form a mode-0 sclk.
// While disabled the divider sits preloaded so the first enabled edge
// raises sclk immediately. Strobes look one edge ahead:
//   rise      - last low cycle, sclk rises on the next edge (if enabled)
//   fall_next - last high cycle, sclk falls on the next edge
module spi_sclk_gen #(
    parameter int CLK_DIV = 3
) (
    input  logic sysclk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall_next
);

    localparam int              DW       = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_r;
    logic          sclk_r;

    // Half-period divider; toggles sclk every CLK_DIV enabled cycles
    always_ff @(posedge sysclk) begin
        if (rst) begin
            div_cnt_r <= DIV_LAST;
            sclk_r    <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= DIV_LAST;
            sclk_r    <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
            sclk_r    <= sclk_r;
        end
    end

    assign sclk      = sclk_r;
    assign rise      = ~sclk_r & (div_cnt_r == DIV_LAST);
    assign fall_next =  sclk_r & (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master shifting one 24-bit frame MSB first and
// capturing the 24-bit MISO response. Define SPI_MASTER_PREAMBLE_EN to
// insert one dummy sclk period (mosi=0, MISO ignored) before the data.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV  = 3,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [MASTER_FRAME_WIDTH-1:0] i_frame,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [MASTER_FRAME_WIDTH-1:0] o_rx_frame,
    output logic                          sclk,
    output logic                          cs,
    output logic                          mosi,
    input  logic                          miso
);

    localparam int MSB = MASTER_FRAME_WIDTH - 1;
    localparam int TW  = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);

    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(CS_IDLE - 1);
    localparam logic [4:0]    BIT_LAST   = 5'(MASTER_FRAME_WIDTH - 1);

    generate
        if (CLK_DIV < 2 || CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 3) begin : g_bad_timing
            $error("spi_master: CLK_DIV>=2, CS_SETUP>=1, CS_HOLD>=1, CS_IDLE>=3 required");
        end
        if (CMD_BITS + ADDR_BITS + PAYLOAD_BITS != MASTER_FRAME_WIDTH) begin : g_bad_frame
            $error("spi_master: frame field widths do not sum to the frame width");
        end
    endgenerate

`ifdef SPI_MASTER_PREAMBLE_EN
    localparam logic [2:0] ST_AFTER_SETUP = ST_PRE;
`else
    localparam logic [2:0] ST_AFTER_SETUP = ST_XFER;
`endif

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [TW-1:0] tmr_r;
    logic [4:0]    bit_cnt_r;
    logic [MSB:0]  tx_r;
    logic [MSB:0]  rx_r;
    logic [MSB:0]  rx_frame_r;
    logic          cs_r;
    logic          mosi_r;
    logic          busy_r;
    logic          done_r;
    logic          first_mosi_s;
    logic          sclk_en_s;
    logic          sclk_s;
    logic          rise_s;
    logic          fall_next_s;

    // With the preamble, mosi stays low until the dummy period ends
`ifdef SPI_MASTER_PREAMBLE_EN
    assign first_mosi_s = 1'b0;
`else
    assign first_mosi_s = i_frame[MSB];
`endif

    // Next-state decode; sclk runs in any cycle whose next state clocks data
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) state_nxt_s = ST_SETUP;
                else         state_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (tmr_r == SETUP_LAST) state_nxt_s = ST_AFTER_SETUP;
                else                     state_nxt_s = ST_SETUP;
            end
            ST_PRE: begin
                if (rise_s) state_nxt_s = ST_XFER;
                else        state_nxt_s = ST_PRE;
            end
            ST_XFER: begin
                if (rise_s && bit_cnt_r == BIT_LAST) state_nxt_s = ST_HOLD;
                else                                 state_nxt_s = ST_XFER;
            end
            ST_HOLD: begin
                if (tmr_r == HOLD_LAST) state_nxt_s = ST_GAP;
                else                    state_nxt_s = ST_HOLD;
            end
            ST_GAP: begin
                if (tmr_r == IDLE_LAST) state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_GAP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign sclk_en_s = (state_nxt_s == ST_PRE) || (state_nxt_s == ST_XFER);

    spi_sclk_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_sclk_gen (
        .sysclk    (sysclk),
        .rst       (rst),
        .en        (sclk_en_s),
        .sclk      (sclk_s),
        .rise      (rise_s),
        .fall_next (fall_next_s)
    );

    // FSM, phase timer, shift registers and registered pin/host outputs
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tmr_r      <= '0;
            bit_cnt_r  <= 5'd0;
            tx_r       <= '0;
            rx_r       <= '0;
            rx_frame_r <= '0;
            cs_r       <= CS_DEASSERT;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= 1'b0;
            // Timer restarts on every state change; only timed states read it
            if (state_nxt_s != state_r) tmr_r <= '0;
            else                        tmr_r <= tmr_r + TW'(1);
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        tx_r      <= i_frame;
                        bit_cnt_r <= 5'd0;
                        busy_r    <= 1'b1;
                        cs_r      <= CS_ASSERT;
                        mosi_r    <= first_mosi_s;
                    end
                end
                ST_SETUP: begin
                    cs_r <= CS_ASSERT;
                end
                ST_PRE: begin
                    if (rise_s) mosi_r <= tx_r[MSB];
                end
                ST_XFER: begin
                    if (fall_next_s) begin
                        rx_r   <= {rx_r[MSB-1:0], miso};
                        tx_r   <= {tx_r[MSB-1:0], 1'b0};
                        mosi_r <= tx_r[MSB-1];
                    end
                    if (rise_s) bit_cnt_r <= bit_cnt_r + 5'd1;
                end
                ST_HOLD: begin
                    mosi_r <= 1'b0;
                    if (state_nxt_s == ST_GAP) begin
                        cs_r       <= CS_DEASSERT;
                        done_r     <= 1'b1;
                        rx_frame_r <= rx_r;
                    end
                end
                ST_GAP: begin
                    if (state_nxt_s == ST_IDLE) busy_r <= 1'b0;
                end
                default: begin
                    cs_r   <= CS_DEASSERT;
                    mosi_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_rx_frame = rx_frame_r;
    assign sclk       = sclk_s;
    assign cs         = cs_r;
    assign mosi       = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master (default build, no
// preamble). Two instances: A with default timing, B with CLK_DIV=2,
// CS_SETUP=1, CS_HOLD=1. A bench-side slave returns a chosen response.
module tb_spi_master;

    logic sysclk = 1'b0;
    always #4 sysclk = ~sysclk;

    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [23:0] i_frame = 24'h0;
    logic        sel = 1'b0;
    logic        loop = 1'b0;
    logic        slv_miso = 1'b0;

    logic        a_busy, a_done, a_sclk, a_cs, a_mosi, a_miso;
    logic [23:0] a_rx;
    logic        b_busy, b_done, b_sclk, b_cs, b_mosi, b_miso;
    logic [23:0] b_rx;
    logic        a_start, b_start;
    logic        m_busy, m_done, m_sclk, m_cs, m_mosi;
    logic [23:0] m_rx;

    assign a_start = i_start & ~sel;
    assign b_start = i_start & sel;
    assign a_miso  = loop ? a_mosi : slv_miso;
    assign b_miso  = loop ? b_mosi : slv_miso;
    assign m_busy  = sel ? b_busy : a_busy;
    assign m_done  = sel ? b_done : a_done;
    assign m_sclk  = sel ? b_sclk : a_sclk;
    assign m_cs    = sel ? b_cs   : a_cs;
    assign m_mosi  = sel ? b_mosi : a_mosi;
    assign m_rx    = sel ? b_rx   : a_rx;

    spi_master dut_a (
        .sysclk(sysclk), .rst(rst), .i_start(a_start), .i_frame(i_frame),
        .o_busy(a_busy), .o_done(a_done), .o_rx_frame(a_rx),
        .sclk(a_sclk), .cs(a_cs), .mosi(a_mosi), .miso(a_miso)
    );

    spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(4)) dut_b (
        .sysclk(sysclk), .rst(rst), .i_start(b_start), .i_frame(i_frame),
        .o_busy(b_busy), .o_done(b_done), .o_rx_frame(b_rx),
        .sclk(b_sclk), .cs(b_cs), .mosi(b_mosi), .miso(b_miso)
    );

    int total = 0;
    int bad   = 0;

    // Observations of one frame, cycle numbers relative to the accept edge
    int          ob_cs_falls, ob_cs_low, ob_done_cnt, ob_done_c, ob_busy_fall;
    int          ob_rises, ob_first_rise, ob_period;
    logic [23:0] ob_mosi_word, ob_rx;
    logic        sn_cs, sn_sclk, sn_mosi, sn_busy;
    logic [23:0] sn_rx;

    // Reference timing for each instance, straight from the frame budget
    function automatic int exp_len(input logic s);
        if (s) return 1 + 24 * 2 * 2 + 1;
        else   return 2 + 24 * 2 * 3 + 2;
    endfunction

    function automatic int exp_period(input logic s);
        if (s) return 4;
        else   return 6;
    endfunction

    // Start a frame, watch the pins cycle by cycle and act as the slave
    task automatic run_frame(input logic [23:0] frame, input logic [23:0] resp,
                             input int rst_at, input logic [511:0] extra);
        logic prev_sclk, prev_cs;
        int   idx;
        ob_cs_falls = 0; ob_cs_low = 0; ob_done_cnt = 0; ob_done_c = -1;
        ob_busy_fall = -1; ob_rises = 0; ob_first_rise = -1; ob_period = -1;
        ob_mosi_word = 24'h0; ob_rx = 24'h0;
        idx = 0;
        slv_miso = resp[23];
        @(negedge sysclk);
        i_frame = frame;
        i_start = 1'b1;
        @(posedge sysclk);
        #1 i_start = 1'b0;
        prev_sclk = 1'b0;
        prev_cs   = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge sysclk);
            if (!m_cs && prev_cs) ob_cs_falls++;
            if (!m_cs) ob_cs_low++;
            if (m_done) begin
                ob_done_cnt++;
                ob_done_c = c;
                ob_rx = m_rx;
            end
            if (m_sclk && !prev_sclk) begin
                ob_rises++;
                ob_mosi_word = {ob_mosi_word[22:0], m_mosi};
                if (ob_rises == 1) ob_first_rise = c;
                if (ob_rises == 2) ob_period = c - ob_first_rise;
            end
            if (!m_sclk && prev_sclk) begin
                idx++;
                slv_miso = (idx < 24) ? resp[23 - idx] : 1'b0;
            end
            if (c == rst_at + 1) begin
                sn_cs = m_cs; sn_sclk = m_sclk; sn_mosi = m_mosi;
                sn_busy = m_busy; sn_rx = m_rx;
            end
            prev_sclk = m_sclk;
            prev_cs   = m_cs;
            if (!m_busy) begin
                ob_busy_fall = c;
                break;
            end
            rst     = (c == rst_at);
            i_start = extra[c];
        end
        rst     = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        sel = 1'b0;
        total++; if (a_cs !== 1'b1)     begin bad++; $display("FAIL reset_cs got=%b want=1", a_cs); end
        total++; if (a_sclk !== 1'b0)   begin bad++; $display("FAIL reset_sclk got=%b want=0", a_sclk); end
        total++; if (a_mosi !== 1'b0)   begin bad++; $display("FAIL reset_mosi got=%b want=0", a_mosi); end
        total++; if (a_busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
        total++; if (a_done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", a_done); end
        total++; if (a_rx !== 24'h0)    begin bad++; $display("FAIL reset_rx got=%h want=000000", a_rx); end
        total++; if (b_cs !== 1'b1)     begin bad++; $display("FAIL reset_cs_b got=%b want=1", b_cs); end
    endtask

    task automatic test_loopback();
        sel = 1'b0; loop = 1'b1;
        run_frame(24'h010380, 24'h0, -1, 512'h0);
        total++; if (ob_rises != 24)          begin bad++; $display("FAIL lb_rises got=%0d want=24", ob_rises); end
        total++; if (ob_mosi_word !== 24'h010380) begin bad++; $display("FAIL lb_mosi got=%h want=010380", ob_mosi_word); end
        total++; if (ob_cs_falls != 1)        begin bad++; $display("FAIL lb_cs_fall got=%0d want=1", ob_cs_falls); end
        total++; if (ob_cs_low != exp_len(1'b0)) begin bad++; $display("FAIL lb_cs_low got=%0d want=%0d", ob_cs_low, exp_len(1'b0)); end
        total++; if (ob_done_c != 149)        begin bad++; $display("FAIL lb_done_cycle got=%0d want=149", ob_done_c); end
        total++; if (ob_done_cnt != 1)        begin bad++; $display("FAIL lb_done_cnt got=%0d want=1", ob_done_cnt); end
        total++; if (ob_rx !== 24'h010380)    begin bad++; $display("FAIL lb_rx got=%h want=010380", ob_rx); end
        total++; if (ob_busy_fall != 153)     begin bad++; $display("FAIL lb_busy_fall got=%0d want=153", ob_busy_fall); end
        total++; if (ob_period != 6)          begin bad++; $display("FAIL lb_period got=%0d want=6", ob_period); end
        @(negedge sysclk);
        total++; if (a_rx !== 24'h010380)     begin bad++; $display("FAIL lb_rx_held got=%h want=010380", a_rx); end
        loop = 1'b0;
    endtask

    task automatic test_random_slave();
        logic [23:0] fr, rs;
        loop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            fr  = 24'($urandom);
            rs  = 24'($urandom);
            sel = 1'($urandom_range(0, 1));
            run_frame(fr, rs, -1, 512'h0);
            total++; if (ob_rx !== rs)       begin bad++; $display("FAIL rnd_rx k=%0d got=%h want=%h", k, ob_rx, rs); end
            total++; if (ob_mosi_word !== fr) begin bad++; $display("FAIL rnd_mosi k=%0d got=%h want=%h", k, ob_mosi_word, fr); end
            total++; if (ob_done_c != 1 + exp_len(sel)) begin bad++; $display("FAIL rnd_done k=%0d got=%0d want=%0d", k, ob_done_c, 1 + exp_len(sel)); end
            total++; if (ob_busy_fall != 5 + exp_len(sel)) begin bad++; $display("FAIL rnd_busy k=%0d got=%0d want=%0d", k, ob_busy_fall, 5 + exp_len(sel)); end
            total++; if (ob_period != exp_period(sel)) begin bad++; $display("FAIL rnd_period k=%0d got=%0d want=%0d", k, ob_period, exp_period(sel)); end
        end
        sel = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [511:0] ex;
        ex = 512'h0;
        ex[10] = 1'b1; ex[150] = 1'b1; ex[152] = 1'b1;
        sel = 1'b0; loop = 1'b1;
        run_frame(24'hA5C33C, 24'h0, -1, ex);
        total++; if (ob_cs_falls != 1)    begin bad++; $display("FAIL ign_cs_falls got=%0d want=1", ob_cs_falls); end
        total++; if (ob_done_cnt != 1)    begin bad++; $display("FAIL ign_done_cnt got=%0d want=1", ob_done_cnt); end
        total++; if (ob_busy_fall != 153) begin bad++; $display("FAIL ign_busy_fall got=%0d want=153", ob_busy_fall); end
        total++; if (ob_rx !== 24'hA5C33C) begin bad++; $display("FAIL ign_rx got=%h want=a5c33c", ob_rx); end
        @(negedge sysclk);
        total++; if (a_cs !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL ign_no_queue got=cs%b/busy%b want=cs1/busy0", a_cs, a_busy); end
        loop = 1'b0;
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; loop = 1'b1;
        run_frame(24'hFFFFFF, 24'h0, 60, 512'h0);
        total++; if (sn_cs !== 1'b1)     begin bad++; $display("FAIL rmid_cs got=%b want=1", sn_cs); end
        total++; if (sn_sclk !== 1'b0)   begin bad++; $display("FAIL rmid_sclk got=%b want=0", sn_sclk); end
        total++; if (sn_mosi !== 1'b0)   begin bad++; $display("FAIL rmid_mosi got=%b want=0", sn_mosi); end
        total++; if (sn_busy !== 1'b0)   begin bad++; $display("FAIL rmid_busy got=%b want=0", sn_busy); end
        total++; if (sn_rx !== 24'h0)    begin bad++; $display("FAIL rmid_rx got=%h want=000000", sn_rx); end
        total++; if (ob_done_cnt != 0)   begin bad++; $display("FAIL rmid_done got=%0d want=0", ob_done_cnt); end
        total++; if (ob_busy_fall != 61) begin bad++; $display("FAIL rmid_busy_fall got=%0d want=61", ob_busy_fall); end
        repeat (2) @(negedge sysclk);
        run_frame(24'h5A0F96, 24'h0, -1, 512'h0);
        total++; if (ob_rx !== 24'h5A0F96) begin bad++; $display("FAIL rmid_next_rx got=%h want=5a0f96", ob_rx); end
        total++; if (ob_done_c != 149)     begin bad++; $display("FAIL rmid_next_done got=%0d want=149", ob_done_c); end
        loop = 1'b0;
    endtask

    task automatic test_div2();
        sel = 1'b1; loop = 1'b1;
        run_frame(24'hFFFFFF, 24'h0, -1, 512'h0);
        total++; if (ob_cs_low != 98)      begin bad++; $display("FAIL d2_len got=%0d want=98", ob_cs_low); end
        total++; if (ob_period != 4)       begin bad++; $display("FAIL d2_period got=%0d want=4", ob_period); end
        total++; if (ob_rx !== 24'hFFFFFF) begin bad++; $display("FAIL d2_rx_ones got=%h want=ffffff", ob_rx); end
        total++; if (ob_done_c != 99)      begin bad++; $display("FAIL d2_done got=%0d want=99", ob_done_c); end
        run_frame(24'h000000, 24'h0, -1, 512'h0);
        total++; if (ob_rx !== 24'h000000) begin bad++; $display("FAIL d2_rx_zeros got=%h want=000000", ob_rx); end
        total++; if (ob_rises != 24)       begin bad++; $display("FAIL d2_rises got=%0d want=24", ob_rises); end
        sel = 1'b0; loop = 1'b0;
    endtask

    task automatic test_rst_start_same();
        int lows;
        sel = 1'b0;
        @(negedge sysclk);
        i_frame = 24'hFFFFFF;
        rst = 1'b1;
        i_start = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        i_start = 1'b0;
        lows = 0;
        for (int c = 0; c < 8; c++) begin
            if (a_cs !== 1'b1 || a_busy !== 1'b0) lows++;
            @(negedge sysclk);
        end
        total++; if (lows != 0) begin bad++; $display("FAIL rst_start got=%0d active cycles want=0", lows); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_reset_mid();
        test_random_slave();
        test_start_ignored();
        test_div2();
        test_rst_start_same();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
